// File: rtl/magic_button_ctrl_pkg.sv
// Shared types and defaults for the magic button front end.
package magic_button_ctrl_pkg;

  typedef enum logic [1:0] {
    MB_IDLE,
    MB_HELD,
    MB_REQ,
    MB_WAIT_REL
  } magicbtn_state_t;

  localparam int unsigned MB_DEBOUNCE_CYCLES = 280000;
  localparam int unsigned MB_LONG_FRAMES     = 100;
  localparam int unsigned MB_REQ_TIMEOUT     = 8;

  // Bits needed for a saturating counter that must be able to hold max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/magic_button_ctrl_if.sv
// Request/acceptance link between the button front end and the magic controller.
interface magic_button_ctrl_if;
  logic magic_button;
  logic reboot_req;
  logic magic_mode;

  modport master (output magic_button, output reboot_req, input magic_mode);
  modport slave  (input magic_button, input reboot_req, output magic_mode);
endinterface

// File: rtl/magic_button_ctrl_debounce.sv
// 2-FF synchroniser plus stable-count debouncer; q follows d once d has differed for STABLE_CYCLES samples.
module magic_button_ctrl_debounce #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        INIT          = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int unsigned CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Counter holds at its top value on the toggle cycle and clears once q matches again.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= INIT;
      s2  <= INIT;
      q   <= INIT;
      cnt <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      if (s2 == q) begin
        cnt <= '0;
      end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
        q <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/magic_button_ctrl.sv
// Magic button front end: debounced short press -> frame-aligned request, long press -> reboot pulse.
// Optional keyboard hotkey path enabled by defining MAGIC_KBD_HOTKEY_EN.
module magic_button_ctrl
  import magic_button_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = MB_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_FRAMES     = MB_LONG_FRAMES,
  parameter int unsigned REQ_TIMEOUT     = MB_REQ_TIMEOUT
) (
  input  logic                       clk28,
  input  logic                       rst,
  input  logic                       n_btn_raw,
  input  logic                       kbd_magic,
  input  logic                       n_int,
  magic_button_ctrl_if.master        mb,
  output logic                       btn_pressed
);

  localparam int unsigned FW = cnt_width(LONG_FRAMES);
  localparam int unsigned RW = cnt_width(REQ_TIMEOUT);

  magicbtn_state_t state;
  magicbtn_state_t state_nxt;
  logic [FW-1:0]   frame_cnt;
  logic [FW-1:0]   frame_cnt_nxt;
  logic [FW-1:0]   frame_inc;
  logic [RW-1:0]   req_cnt;
  logic [RW-1:0]   req_cnt_nxt;
  logic [RW-1:0]   req_inc;
  logic            magic_button_q;
  logic            magic_button_nxt;
  logic            reboot_req_q;
  logic            reboot_req_nxt;
  logic            n_btn_db;
  logic            btn_prev;
  logic            n_int_q;
  logic            n_int_qq;
  logic            tick_c;
  logic            press_c;
  logic            kbd_rise_c;

  magic_button_ctrl_debounce #(
    .STABLE_CYCLES (DEBOUNCE_CYCLES),
    .INIT          (1'b1)
  ) u_btn_db (
    .clk (clk28),
    .rst (rst),
    .d   (n_btn_raw),
    .q   (n_btn_db)
  );

  assign btn_pressed     = ~n_btn_db;
  assign mb.magic_button = magic_button_q;
  assign mb.reboot_req   = reboot_req_q;

`ifdef MAGIC_KBD_HOTKEY_EN
  logic kbd_s1;
  logic kbd_s2;
  logic kbd_prev;

  // Keyboard level is already clean; synchronise only.
  always_ff @(posedge clk28) begin
    if (rst) begin
      kbd_s1   <= 1'b0;
      kbd_s2   <= 1'b0;
      kbd_prev <= 1'b0;
    end else begin
      kbd_s1   <= kbd_magic;
      kbd_s2   <= kbd_s1;
      kbd_prev <= kbd_s2;
    end
  end

  assign kbd_rise_c = kbd_s2 & ~kbd_prev;
`else
  logic unused_kbd;
  assign unused_kbd = kbd_magic;
  assign kbd_rise_c = 1'b0;
`endif

  // Frame tick and press-edge detection.
  always_ff @(posedge clk28) begin
    if (rst) begin
      n_int_q  <= 1'b1;
      n_int_qq <= 1'b1;
      btn_prev <= 1'b0;
    end else begin
      n_int_q  <= n_int;
      n_int_qq <= n_int_q;
      btn_prev <= btn_pressed;
    end
  end

  assign tick_c  = n_int_qq & ~n_int_q;
  assign press_c = btn_pressed & ~btn_prev;

  assign frame_inc = (frame_cnt == FW'(LONG_FRAMES)) ? frame_cnt : frame_cnt + FW'(1);
  assign req_inc   = (req_cnt == RW'(REQ_TIMEOUT)) ? req_cnt : req_cnt + RW'(1);

  always_ff @(posedge clk28) begin
    if (rst) begin
      state          <= MB_IDLE;
      frame_cnt      <= '0;
      req_cnt        <= '0;
      magic_button_q <= 1'b0;
      reboot_req_q   <= 1'b0;
    end else begin
      state          <= state_nxt;
      frame_cnt      <= frame_cnt_nxt;
      req_cnt        <= req_cnt_nxt;
      magic_button_q <= magic_button_nxt;
      reboot_req_q   <= reboot_req_nxt;
    end
  end

  // A tick reaching the long-press limit beats a release on the same cycle.
  always_comb begin
    state_nxt        = state;
    frame_cnt_nxt    = frame_cnt;
    req_cnt_nxt      = req_cnt;
    magic_button_nxt = 1'b0;
    reboot_req_nxt   = 1'b0;
    unique case (state)
      MB_IDLE: begin
        if (press_c) begin
          state_nxt     = MB_HELD;
          frame_cnt_nxt = '0;
        end else if (kbd_rise_c) begin
          state_nxt        = MB_REQ;
          req_cnt_nxt      = '0;
          magic_button_nxt = 1'b1;
        end
      end
      MB_HELD: begin
        if (tick_c) begin
          frame_cnt_nxt = frame_inc;
        end
        if (tick_c && (frame_inc == FW'(LONG_FRAMES))) begin
          state_nxt      = MB_WAIT_REL;
          reboot_req_nxt = 1'b1;
        end else if (!btn_pressed) begin
          state_nxt        = MB_REQ;
          req_cnt_nxt      = '0;
          magic_button_nxt = 1'b1;
        end
      end
      MB_REQ: begin
        magic_button_nxt = 1'b1;
        if (tick_c) begin
          req_cnt_nxt = req_inc;
        end
        // Acceptance only counts once the controller has seen at least one frame.
        if ((mb.magic_mode && (req_cnt != '0)) ||
            (tick_c && (req_inc == RW'(REQ_TIMEOUT)))) begin
          state_nxt        = MB_IDLE;
          magic_button_nxt = 1'b0;
        end
      end
      MB_WAIT_REL: begin
        if (!btn_pressed) begin
          state_nxt = MB_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_magic_button_ctrl.sv
// Directed bench for magic_button_ctrl with shortened debounce/frame parameters.
module tb_magic_button_ctrl;

  logic clk28;
  logic rst;
  logic n_btn_raw;
  logic kbd_magic;
  logic n_int;
  logic btn_pressed;

  magic_button_ctrl_if mbif ();

  magic_button_ctrl #(
    .DEBOUNCE_CYCLES (16),
    .LONG_FRAMES     (4),
    .REQ_TIMEOUT     (3)
  ) dut (
    .clk28       (clk28),
    .rst         (rst),
    .n_btn_raw   (n_btn_raw),
    .kbd_magic   (kbd_magic),
    .n_int       (n_int),
    .mb          (mbif),
    .btn_pressed (btn_pressed)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  int n_chk = 0;
  int n_err = 0;

  // Pulse/level monitor sampled on the falling edge.
  int   rb_cnt  = 0;
  int   rb_wide = 0;
  int   mb_hi   = 0;
  logic rb_last = 1'b0;
  always @(negedge clk28) begin
    if (mbif.reboot_req === 1'b1) begin
      rb_cnt = rb_cnt + 1;
      if (rb_last) rb_wide = rb_wide + 1;
    end
    rb_last = (mbif.reboot_req === 1'b1);
    if (mbif.magic_button === 1'b1) mb_hi = mb_hi + 1;
  end

  typedef struct {
    logic rst;
    logic n_btn;
    logic n_int;
    logic mode;
    int   ncyc;
    logic e_pr;
    logic e_mb;
    logic e_rb;
  } vec_t;

  vec_t vt[12];

  task automatic cycles(input int n);
    repeat (n) @(posedge clk28);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  // Press and release long enough to debounce both edges; lands in REQ.
  task automatic short_press();
    n_btn_raw = 1'b0;
    cycles(25);
    n_btn_raw = 1'b1;
    cycles(20);
  endtask

  task automatic run_frame();
    n_int = 1'b0;
    cycles(10);
    n_int = 1'b1;
    cycles(90);
  endtask

  int rb_base;
  int mb_base;
  int wide_base;

  initial begin
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0,  3, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b0,  5, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 17, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0,  5, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 17, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b1,  5, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b1,  4, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0};

    rst             = 1'b1;
    n_btn_raw       = 1'b1;
    kbd_magic       = 1'b0;
    n_int           = 1'b1;
    mbif.magic_mode = 1'b0;
    #1;

    // Table: reset, debounce latency, short press, accept after first tick.
    for (int i = 0; i < 12; i++) begin
      rst             = vt[i].rst;
      n_btn_raw       = vt[i].n_btn;
      n_int           = vt[i].n_int;
      mbif.magic_mode = vt[i].mode;
      cycles(vt[i].ncyc);
      check($sformatf("vec%0d_btn_pressed", i), btn_pressed, vt[i].e_pr);
      check($sformatf("vec%0d_magic_button", i), mbif.magic_button, vt[i].e_mb);
      check($sformatf("vec%0d_reboot_req", i), mbif.reboot_req, vt[i].e_rb);
    end

    // Bounce: toggles every 5 cycles, then stays low; rise exactly 18 cycles later.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      n_btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
      cycles(5);
      check($sformatf("bounce%0d_no_press", i), btn_pressed, 1'b0);
    end
    n_btn_raw = 1'b0;
    cycles(17);
    check("bounce_cycle17", btn_pressed, 1'b0);
    cycles(1);
    check("bounce_cycle18", btn_pressed, 1'b1);
    n_btn_raw = 1'b1;
    do_reset();

    // Short press, acceptance 10 cycles after the tick.
    short_press();
    check("acc_req_up", mbif.magic_button, 1'b1);
    n_int = 1'b0;
    cycles(10);
    check("acc_after_tick_no_mode", mbif.magic_button, 1'b1);
    mbif.magic_mode = 1'b1;
    cycles(1);
    check("acc_drop_next_edge", mbif.magic_button, 1'b0);
    mbif.magic_mode = 1'b0;
    n_int = 1'b1;
    cycles(90);

    // Short press never accepted: drops on the 3rd tick.
    short_press();
    run_frame();
    check("tmo_frame1", mbif.magic_button, 1'b1);
    run_frame();
    check("tmo_frame2", mbif.magic_button, 1'b1);
    run_frame();
    check("tmo_frame3", mbif.magic_button, 1'b0);

    // Long press held for 5 frames.
    rb_base   = rb_cnt;
    mb_base   = mb_hi;
    wide_base = rb_wide;
    n_btn_raw = 1'b0;
    cycles(25);
    for (int f = 1; f <= 5; f++) begin
      run_frame();
      check_int($sformatf("long_rb_after_frame%0d", f), rb_cnt - rb_base, (f >= 4) ? 1 : 0);
    end
    check_int("long_rb_width", rb_wide - wide_base, 0);
    n_btn_raw = 1'b1;
    cycles(30);
    check("long_released", btn_pressed, 1'b0);
    check("long_no_req", mbif.magic_button, 1'b0);
    check_int("long_mb_never", mb_hi - mb_base, 0);
    short_press();
    check("long_then_idle_short", mbif.magic_button, 1'b1);
    run_frame();
    run_frame();
    run_frame();
    check("long_then_idle_cleared", mbif.magic_button, 1'b0);

    // Reset while in REQ.
    short_press();
    check("rst_pre_req", mbif.magic_button, 1'b1);
    rb_base = rb_cnt;
    rst = 1'b1;
    cycles(1);
    check("rst_mb_low", mbif.magic_button, 1'b0);
    rst = 1'b0;
    cycles(5);
    check_int("rst_no_reboot", rb_cnt - rb_base, 0);
    short_press();
    check("rst_new_press", mbif.magic_button, 1'b1);
    do_reset();

    // magic_mode already high on entry: held until a tick passes.
    mbif.magic_mode = 1'b1;
    short_press();
    check("pre_mode_req_up", mbif.magic_button, 1'b1);
    cycles(30);
    check("pre_mode_held", mbif.magic_button, 1'b1);
    run_frame();
    check("pre_mode_dropped", mbif.magic_button, 1'b0);
    mbif.magic_mode = 1'b0;

    // Press during REQ is ignored.
    short_press();
    n_btn_raw = 1'b0;
    cycles(25);
    check("req_repress_held", mbif.magic_button, 1'b1);
    n_btn_raw = 1'b1;
    cycles(25);
    check("req_repress_released", mbif.magic_button, 1'b1);
    run_frame();
    run_frame();
    run_frame();
    check("req_repress_timeout", mbif.magic_button, 1'b0);
    cycles(10);
    check("req_repress_idle", mbif.magic_button, 1'b0);

    // Release after LONG_FRAMES-1 ticks is still a short press.
    rb_base = rb_cnt;
    n_btn_raw = 1'b0;
    cycles(25);
    run_frame();
    run_frame();
    run_frame();
    n_btn_raw = 1'b1;
    cycles(20);
    check("near_long_short_req", mbif.magic_button, 1'b1);
    check_int("near_long_no_reboot", rb_cnt - rb_base, 0);
    run_frame();
    run_frame();
    run_frame();
    check("near_long_cleared", mbif.magic_button, 1'b0);

    // Keyboard hotkey.
    rb_base = rb_cnt;
`ifdef MAGIC_KBD_HOTKEY_EN
    kbd_magic = 1'b1;
    cycles(3);
    check("kbd_req_within3", mbif.magic_button, 1'b1);
    for (int f = 0; f < 10; f++) run_frame();
    check("kbd_long_no_req", mbif.magic_button, 1'b0);
    check_int("kbd_no_reboot", rb_cnt - rb_base, 0);
    kbd_magic = 1'b0;
    cycles(5);
`else
    kbd_magic = 1'b1;
    cycles(10);
    check("kbd_ignored", mbif.magic_button, 1'b0);
    check_int("kbd_no_reboot", rb_cnt - rb_base, 0);
    kbd_magic = 1'b0;
    cycles(5);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
